score_keeper: RTL

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 136 +++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Snake-game score keeper: edge-detected collision/restart events drive a PLAYING/OVER/WIN game state.
// Optional BCD score outputs are enabled by defining SCORE_KEEPER_SCORE_BCD_EN.
module score_keeper #(
    parameter int unsigned SCORE_W   = 7,
    parameter int unsigned WIN_SCORE = 100
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               goodColl,
    input  logic               badColl,
    input  logic               restart,
    output logic [SCORE_W-1:0] currScore,
    output logic [SCORE_W-1:0] highScore,
    output logic               isGameComplete,
    output logic [1:0]         gameState,
    output logic               newHigh
`ifdef SCORE_KEEPER_SCORE_BCD_EN
    ,
    output logic [11:0]        currBcd,
    output logic [11:0]        highBcd
`endif
);

    localparam int unsigned MAX_SCORE = (1 << SCORE_W) - 1;
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    // Reject configurations the score registers cannot represent.
    if (SCORE_W < 4 || SCORE_W > 9) begin : g_bad_score_w
        $error("score_keeper: SCORE_W must be within 4..9");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > MAX_SCORE) begin : g_bad_win_score
        $error("score_keeper: WIN_SCORE must be within 1..2**SCORE_W-1");
    end

    typedef enum logic [1:0] {
        ST_PLAYING = 2'b00,
        ST_OVER    = 2'b01,
        ST_WIN     = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] curr_q, curr_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;
    logic               complete_q, complete_d;
    logic               good_prev_q, bad_prev_q, restart_prev_q;

    logic               good_ev, bad_ev, restart_ev;
    logic [SCORE_W-1:0] curr_inc;

    assign good_ev    = goodColl & ~good_prev_q;
    assign bad_ev     = badColl & ~bad_prev_q;
    assign restart_ev = restart & ~restart_prev_q;
    assign curr_inc   = curr_q + SCORE_W'(1);

    // Next-state and next-score decision; a bad collision always beats an apple.
    always_comb begin
        state_d    = state_q;
        curr_d     = curr_q;
        high_d     = high_q;
        new_high_d = 1'b0;
        unique case (state_q)
            ST_PLAYING: begin
                if (bad_ev) begin
                    state_d = ST_OVER;
                end else if (good_ev && (curr_q < WIN_S)) begin
                    curr_d = curr_inc;
                    if (curr_inc > high_q) begin
                        high_d     = curr_inc;
                        new_high_d = 1'b1;
                    end
                    if (curr_inc == WIN_S) begin
                        state_d = ST_WIN;
                    end
                end
            end
            ST_OVER, ST_WIN: begin
                if (restart_ev) begin
                    curr_d  = '0;
                    state_d = ST_PLAYING;
                end
            end
            default: begin
                state_d = ST_PLAYING;
            end
        endcase
        complete_d = (state_d != ST_PLAYING);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= ST_PLAYING;
            curr_q         <= '0;
            high_q         <= '0;
            new_high_q     <= 1'b0;
            complete_q     <= 1'b0;
            good_prev_q    <= 1'b0;
            bad_prev_q     <= 1'b0;
            restart_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            curr_q         <= curr_d;
            high_q         <= high_d;
            new_high_q     <= new_high_d;
            complete_q     <= complete_d;
            good_prev_q    <= goodColl;
            bad_prev_q     <= badColl;
            restart_prev_q <= restart;
        end
    end

    assign currScore      = curr_q;
    assign highScore      = high_q;
    assign gameState      = state_q;
    assign isGameComplete = complete_q;
    assign newHigh        = new_high_q;

`ifdef SCORE_KEEPER_SCORE_BCD_EN
    // Shift-and-add-3 conversion; 9-bit scores never exceed three digits.
    function automatic logic [11:0] to_bcd(input logic [SCORE_W-1:0] bin);
        logic [11:0] bcd;
        bcd = '0;
        for (int i = int'(SCORE_W) - 1; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            if (bcd[11:8] >= 4'd5) bcd[11:8] = bcd[11:8] + 4'd3;
            bcd = {bcd[10:0], bin[i]};
        end
        return bcd;
    endfunction

    assign currBcd = to_bcd(curr_q);
    assign highBcd = to_bcd(high_q);
`endif

endmodule
